keypad_scanner: RTL

- Scanned-input counterpart of the multiplexed 4-digit seven-segment driver.
- Drives one active-low column strobe at a time onto a 4x4 matrix keypad on a Pmod header and samples the four active-low row lines.
- Rejects multi-key (ghost) scans and debounces over whole scans.
- Presents a 4-bit hex key code with a one-cycle valid pulse and a held level, for use as the hex_num source in the display path.

---
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column strobe at a time,
// ghost rejection per scan and whole-scan debounce of press and release.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

    function automatic logic [3:0] key_at(input logic [1:0] c,
                                          input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'h0: k = 4'h1;
            4'h1: k = 4'h4;
            4'h2: k = 4'h7;
            4'h3: k = 4'h0;
            4'h4: k = 4'h2;
            4'h5: k = 4'h5;
            4'h6: k = 4'h8;
            4'h7: k = 4'hF;
            4'h8: k = 4'h3;
            4'h9: k = 4'h6;
            4'hA: k = 4'h9;
            4'hB: k = 4'hE;
            4'hC: k = 4'hA;
            4'hD: k = 4'hB;
            4'hE: k = 4'hC;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [CW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_code;
    state_t        state;
    logic [3:0]    stored;
    logic [DW-1:0] deb_cnt;

    logic          sample;
    logic          scan_end;
    logic [2:0]    row_pop;
    logic [3:0]    tot;
    logic [1:0]    cnt_nxt;
    logic [1:0]    first_row;
    logic [3:0]    samp_code;
    logic [3:0]    res_code;
    logic          res_key;
    logic          match;
    logic [DW-1:0] deb_nxt;

    assign col = ~(4'b0001 << col_idx);

    always_comb begin
        sample   = (dwell == DWELL_LAST);
        scan_end = sample && (col_idx == 2'd3);
        row_pop  = {2'b00, ~row[0]} + {2'b00, ~row[1]}
                 + {2'b00, ~row[2]} + {2'b00, ~row[3]};
        if (!row[0])      first_row = 2'd0;
        else if (!row[1]) first_row = 2'd1;
        else if (!row[2]) first_row = 2'd2;
        else              first_row = 2'd3;
        samp_code = key_at(col_idx, first_row);
        // Count saturates at 2: anything past one key is a ghost scan.
        tot      = {2'b00, acc_cnt} + {1'b0, row_pop};
        cnt_nxt  = (tot >= 4'd2) ? 2'd2 : tot[1:0];
        res_code = (acc_cnt != 2'd0) ? acc_code : samp_code;
        res_key  = (cnt_nxt == 2'd1);
        match    = res_key && (res_code == stored);
        deb_nxt  = deb_cnt + DW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell    <= '0;
            col_idx  <= 2'd0;
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else if (sample) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            if (scan_end) begin
                acc_cnt  <= 2'd0;
                acc_code <= 4'h0;
            end else begin
                acc_cnt <= cnt_nxt;
                if (acc_cnt == 2'd0 && row_pop != 3'd0)
                    acc_code <= samp_code;
            end
        end else begin
            dwell <= dwell + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stored    <= 4'h0;
            deb_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                unique case (state)
                    IDLE: if (res_key) begin
                        stored  <= res_code;
                        deb_cnt <= DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state     <= HELD;
                            key_code  <= res_code;
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                        end else begin
                            state <= PRESS_CHK;
                        end
                    end
                    PRESS_CHK: if (match) begin
                        deb_cnt <= deb_nxt;
                        if (deb_nxt == DEB_LAST) begin
                            state     <= HELD;
                            key_code  <= stored;
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                    HELD: if (!match) begin
                        deb_cnt <= DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end else begin
                            state <= RELEASE_CHK;
                        end
                    end
                    RELEASE_CHK: if (match) begin
                        state <= HELD;
                    end else begin
                        deb_cnt <= deb_nxt;
                        if (deb_nxt == DEB_LAST) begin
                            state    <= IDLE;
                            key_down <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
